// File: rtl/sample_deserializer_if.sv
// Byte-pair deserializer bus: pin-side byte strobe in, assembled samples and status out.
interface sample_deserializer_if #(
    parameter int NUM_UNITS  = 2,
    parameter int DATA_WIDTH = 16
);
    logic                  ena;
    logic [7:0]            byte_in;
    logic                  byte_valid;
    logic [1:0]            unit_sel;
    logic [DATA_WIDTH-1:0] sample_out;
    logic                  sample_valid;
    logic [1:0]            sample_unit;
    logic [NUM_UNITS-1:0]  unit_valid;
    logic                  busy;
    logic                  frame_err;
    logic [7:0]            err_count;

    // Byte source side.
    modport master (
        output ena, byte_in, byte_valid, unit_sel,
        input  sample_out, sample_valid, sample_unit, unit_valid, busy, frame_err, err_count
    );

    // Deserializer side.
    modport slave (
        input  ena, byte_in, byte_valid, unit_sel,
        output sample_out, sample_valid, sample_unit, unit_valid, busy, frame_err, err_count
    );
endinterface

// File: rtl/sample_deserializer.sv
// Assembles MSB-first byte pairs from a pin-level strobe into per-channel samples,
// with channel-mismatch, bad-channel and LSB-timeout error detection.
module sample_deserializer #(
    parameter int NUM_UNITS      = 2,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic                clk,
    input logic                rst,
    sample_deserializer_if.slave bus
);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic {
        WAIT_MSB,
        WAIT_LSB
    } state_t;

    // Input pipeline
    logic       v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [7:0] d1_q, d1_d, d2_q, d2_d;

    // FSM and pair datapath
    state_t     state_q, state_d;
    logic [7:0] msb_q, msb_d;
    logic [1:0] unit_q, unit_d;
    logic [TW-1:0] tcnt_q, tcnt_d;

    // Assembled word, one stage ahead of the outputs
    logic        asm_stb_q, asm_stb_d;
    logic [15:0] asm_data_q, asm_data_d;
    logic [1:0]  asm_unit_q, asm_unit_d;

    // Outputs
    logic [DATA_WIDTH-1:0] sample_out_q, sample_out_d;
    logic                  sample_valid_q, sample_valid_d;
    logic [1:0]            sample_unit_q, sample_unit_d;
    logic [NUM_UNITS-1:0]  unit_valid_q, unit_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic [7:0]            err_count_q, err_count_d;

    logic byte_evt;
    logic unit_ok;
    logic err_pulse;

    // Two-stage pin synchroniser plus edge-detect history.
    always_comb begin
        v1_d = bus.byte_valid;
        d1_d = bus.byte_in;
        v2_d = v1_q;
        d2_d = d1_q;
        v3_d = v2_q;
    end

    // Pipeline registers keep running regardless of ena.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            d1_q <= '0;
            d2_q <= '0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
            d1_q <= d1_d;
            d2_q <= d2_d;
        end
    end

    // Next-state, pair assembly, timeout and error accounting.
    always_comb begin
        byte_evt   = v2_q & ~v3_q & bus.ena;
        unit_ok    = int'(bus.unit_sel) < NUM_UNITS;
        state_d    = state_q;
        msb_d      = msb_q;
        unit_d     = unit_q;
        tcnt_d     = tcnt_q;
        asm_stb_d  = 1'b0;
        asm_data_d = asm_data_q;
        asm_unit_d = asm_unit_q;
        err_pulse  = 1'b0;

        case (state_q)
            WAIT_MSB: begin
                if (byte_evt) begin
                    if (unit_ok) begin
                        msb_d   = d2_q;
                        unit_d  = bus.unit_sel;
                        tcnt_d  = '0;
                        state_d = WAIT_LSB;
                    end else begin
                        err_pulse = 1'b1;
                    end
                end
            end
            WAIT_LSB: begin
                // A byte arriving on the timeout cycle takes priority over the timeout.
                if (byte_evt) begin
                    if (bus.unit_sel == unit_q) begin
                        asm_stb_d  = 1'b1;
                        asm_data_d = {msb_q, d2_q};
                        asm_unit_d = unit_q;
                        state_d    = WAIT_MSB;
                    end else begin
                        // Channel switch: drop the held MSB, reuse this byte as a new MSB.
                        err_pulse = 1'b1;
                        if (unit_ok) begin
                            msb_d   = d2_q;
                            unit_d  = bus.unit_sel;
                            tcnt_d  = '0;
                        end else begin
                            state_d = WAIT_MSB;
                        end
                    end
                end else if (bus.ena) begin
                    if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        state_d   = WAIT_MSB;
                        err_pulse = 1'b1;
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
            end
            default: state_d = WAIT_MSB;
        endcase

        frame_err_d = err_pulse;
        err_count_d = (err_pulse && (err_count_q != 8'hFF)) ? err_count_q + 8'd1 : err_count_q;
    end

    // FSM state and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= WAIT_MSB;
            msb_q       <= '0;
            unit_q      <= '0;
            tcnt_q      <= '0;
            asm_stb_q   <= 1'b0;
            asm_data_q  <= '0;
            asm_unit_q  <= '0;
            frame_err_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            msb_q       <= msb_d;
            unit_q      <= unit_d;
            tcnt_q      <= tcnt_d;
            asm_stb_q   <= asm_stb_d;
            asm_data_q  <= asm_data_d;
            asm_unit_q  <= asm_unit_d;
            frame_err_q <= frame_err_d;
            err_count_q <= err_count_d;
        end
    end

    // Output stage: publish the assembled word and hold it between pulses.
    always_comb begin
        sample_valid_d = asm_stb_q;
        sample_out_d   = asm_stb_q ? asm_data_q : sample_out_q;
        sample_unit_d  = asm_stb_q ? asm_unit_q : sample_unit_q;
        unit_valid_d   = '0;
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            unit_valid_d[i] = asm_stb_q && (32'(asm_unit_q) == i);
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_out_q   <= '0;
            sample_valid_q <= 1'b0;
            sample_unit_q  <= '0;
            unit_valid_q   <= '0;
        end else begin
            sample_out_q   <= sample_out_d;
            sample_valid_q <= sample_valid_d;
            sample_unit_q  <= sample_unit_d;
            unit_valid_q   <= unit_valid_d;
        end
    end

    assign bus.sample_out   = sample_out_q;
    assign bus.sample_valid = sample_valid_q;
    assign bus.sample_unit  = sample_unit_q;
    assign bus.unit_valid   = unit_valid_q;
    assign bus.busy         = (state_q == WAIT_LSB);
    assign bus.frame_err    = frame_err_q;
    assign bus.err_count    = err_count_q;
endmodule

// File: tb/tb_sample_deserializer.sv
// Scoreboard bench for sample_deserializer: directed byte sequences push expected
// samples; a negedge monitor pops and compares each sample_valid pulse.
module tb_sample_deserializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sample_deserializer_if #(.NUM_UNITS(2), .DATA_WIDTH(16)) bus ();

    sample_deserializer #(
        .NUM_UNITS(2),
        .DATA_WIDTH(16),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [15:0] data;
        logic [1:0]  unit;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;
    int   fe_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: count error pulses, compare every published sample against the queue.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.frame_err) fe_seen++;
            if (bus.sample_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_sample", {16'h0, bus.sample_out}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("sample_out", {16'h0, bus.sample_out}, {16'h0, e.data});
                    check("sample_unit", {30'h0, bus.sample_unit}, {30'h0, e.unit});
                    check("unit_valid", {30'h0, bus.unit_valid}, 32'(2'b01 << e.unit));
                    check("latency_cycle", cyc, e.cyc);
                end
            end else if (bus.unit_valid != 2'b00) begin
                check("unit_valid_idle", {30'h0, bus.unit_valid}, 32'h0);
            end
        end
    end

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at posedge+1; strobes one byte for 'hold' cycles then idles 'gap' cycles.
    task automatic send_byte(input logic [7:0] b, input logic [1:0] u, input int hold, input int gap);
        bus.byte_in    = b;
        bus.unit_sel   = u;
        bus.byte_valid = 1'b1;
        repeat (hold) @(posedge clk);
        #1 bus.byte_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
    endtask

    // Expected pulse: drive at cycle N, sampled at edge N+1, published after edge N+4.
    task automatic push_exp(input logic [15:0] data, input logic [1:0] u);
        exp_t e;
        e.data = data;
        e.unit = u;
        e.cyc  = cyc + 4;
        exp_q.push_back(e);
    endtask

    task automatic send_pair(input logic [7:0] m, input logic [7:0] l, input logic [1:0] u, input int gap);
        send_byte(m, u, 1, 1);
        push_exp({m, l}, u);
        send_byte(l, u, 1, gap);
    endtask

    int n0;
    int fe0;

    initial begin
        bus.ena        = 1'b1;
        bus.byte_in    = '0;
        bus.byte_valid = 1'b0;
        bus.unit_sel   = '0;

        // Reset state
        #12;
        check("rst_busy", {31'h0, bus.busy}, 32'h0);
        check("rst_sample_valid", {31'h0, bus.sample_valid}, 32'h0);
        check("rst_sample_out", {16'h0, bus.sample_out}, 32'h0);
        check("rst_err_count", {24'h0, bus.err_count}, 32'h0);
        check("rst_frame_err", {31'h0, bus.frame_err}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        settle(2);

        // Single pair on unit 1
        send_pair(8'h12, 8'h34, 2'd1, 1);
        settle(6);
        check("pair1_busy", {31'h0, bus.busy}, 32'h0);

        // Back-to-back pairs on different units, no errors
        fe0 = fe_seen;
        send_pair(8'h80, 8'h01, 2'd0, 2);
        send_pair(8'h7F, 8'hFF, 2'd1, 1);
        settle(6);
        check("b2b_no_frame_err", fe_seen - fe0, 32'h0);
        check("b2b_err_count", {24'h0, bus.err_count}, 32'h0);

        // LSB timeout: MSB event lands at edge n0+3, timeout at edge n0+3+64
        n0 = cyc;
        send_byte(8'hAA, 2'd0, 1, 1);
        wait_cyc(n0 + 66);
        check("timeout_busy_before", {31'h0, bus.busy}, 32'h1);
        wait_cyc(n0 + 67);
        check("timeout_busy_after", {31'h0, bus.busy}, 32'h0);
        check("timeout_frame_err", {31'h0, bus.frame_err}, 32'h1);
        check("timeout_err_count", {24'h0, bus.err_count}, 32'h1);
        settle(2);
        send_pair(8'h01, 8'h02, 2'd0, 1);
        settle(6);

        // Channel switch mid-pair: new byte becomes the MSB
        send_byte(8'h11, 2'd0, 1, 2);
        send_byte(8'h55, 2'd1, 1, 2);
        check("switch_busy", {31'h0, bus.busy}, 32'h1);
        check("switch_err_count", {24'h0, bus.err_count}, 32'h2);
        push_exp(16'h5566, 2'd1);
        send_byte(8'h66, 2'd1, 1, 2);
        settle(6);

        // Strobe held high for 5 cycles counts once
        send_byte(8'h77, 2'd0, 5, 2);
        check("hold_busy", {31'h0, bus.busy}, 32'h1);
        push_exp(16'h7788, 2'd0);
        send_byte(8'h88, 2'd0, 1, 2);
        settle(6);
        check("hold_done_busy", {31'h0, bus.busy}, 32'h0);

        // Out-of-range channel in WAIT_MSB
        send_byte(8'h99, 2'd3, 1, 2);
        check("badunit_busy", {31'h0, bus.busy}, 32'h0);
        check("badunit_err_count", {24'h0, bus.err_count}, 32'h3);

        // ena low: byte not accepted
        bus.ena = 1'b0;
        send_byte(8'h42, 2'd0, 1, 2);
        settle(2);
        check("ena_low_busy", {31'h0, bus.busy}, 32'h0);
        check("ena_low_err_count", {24'h0, bus.err_count}, 32'h3);
        bus.ena = 1'b1;
        settle(1);

        // ena low freezes the timeout while an MSB is held
        send_byte(8'hC3, 2'd0, 1, 2);
        bus.ena = 1'b0;
        settle(100);
        check("freeze_busy", {31'h0, bus.busy}, 32'h1);
        check("freeze_err_count", {24'h0, bus.err_count}, 32'h3);
        bus.ena = 1'b1;
        push_exp(16'hC35A, 2'd0);
        send_byte(8'h5A, 2'd0, 1, 2);
        settle(16);
        check("hold_sample_out", {16'h0, bus.sample_out}, 32'hC35A);
        check("hold_sample_unit", {30'h0, bus.sample_unit}, 32'h0);

        // Reset mid-pair discards the MSB and clears the error count
        send_byte(8'hAB, 2'd0, 1, 2);
        check("pre_rst_busy", {31'h0, bus.busy}, 32'h1);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", {31'h0, bus.busy}, 32'h0);
        check("midrst_err_count", {24'h0, bus.err_count}, 32'h0);
        check("midrst_sample_out", {16'h0, bus.sample_out}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        settle(2);
        send_pair(8'hCD, 8'hEF, 2'd1, 2);
        settle(6);
        check("post_rst_err_count", {24'h0, bus.err_count}, 32'h0);

        // 300 malformed events saturate the counter at 255
        fe0 = fe_seen;
        repeat (300) send_byte(8'h3C, 2'd3, 1, 1);
        settle(4);
        check("sat_err_count", {24'h0, bus.err_count}, 32'hFF);
        check("sat_frame_err_pulses", fe_seen - fe0, 32'd300);

        settle(4);
        check("scoreboard_empty", exp_q.size(), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/sample_deserializer.md
SAMPLE_DESERIALIZER -- requirements
Module: sample_deserializer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter NUM_UNITS, default 2: number of detector channels, 1..4.
REQ-003 Parameter DATA_WIDTH, default 16: sample width, fixed at 2 bytes.
REQ-004 Parameter TIMEOUT_CYCLES, default 64: maximum wait for the LSB after an MSB is accepted.
REQ-005 clk  in  1  system clock, rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 ena  in  1  enable; while low, no new byte is accepted.
REQ-008 byte_in  in  8  sample byte from the pins, MSB first.
REQ-009 byte_valid  in  1  byte strobe, level from the pins.
REQ-010 unit_sel  in  2  target channel for the byte pair.
REQ-011 sample_out  out  DATA_WIDTH  assembled sample {MSB,LSB}.
REQ-012 sample_valid  out  1  one-cycle pulse when sample_out is new.
REQ-013 sample_unit  out  2  channel of sample_out.
REQ-014 unit_valid  out  NUM_UNITS  one-hot copy of sample_valid per channel.
REQ-015 busy  out  1  high while an MSB is held and the LSB is pending.
REQ-016 frame_err  out  1  one-cycle pulse on any discarded byte or pair.
REQ-017 err_count  out  8  saturating count of frame_err pulses.

Function
REQ-018 byte_valid and byte_in SHALL pass together through a 2-stage register pipeline (v1/d1, v2/d2); v3 SHALL hold the previous v2.
REQ-019 A byte event SHALL be v2 & ~v3 & ena; it captures d2. Every byte needs a fresh rising edge, and a held-high strobe counts once.
REQ-020 FSM states SHALL be WAIT_MSB and WAIT_LSB, with WAIT_MSB as the reset state.
REQ-021 WAIT_MSB, on a byte event with unit_sel < NUM_UNITS: store d2 as msb_reg, latch unit_sel into unit_reg, clear the timeout counter, and go to WAIT_LSB.
REQ-022 WAIT_MSB, on a byte event with unit_sel >= NUM_UNITS: discard the byte, pulse frame_err, and stay in WAIT_MSB.
REQ-023 WAIT_LSB, on a byte event with unit_sel == unit_reg: register sample_out = {msb_reg, d2} and sample_unit = unit_reg, pulse sample_valid and unit_valid[unit_reg] on the next cycle, and go to WAIT_MSB.
REQ-024 WAIT_LSB, on a byte event with unit_sel != unit_reg: drop the held MSB, pulse frame_err, and treat d2 as a new MSB under REQ-021 or REQ-022.
REQ-025 WAIT_LSB, with no event: increment the timeout counter. When it reaches TIMEOUT_CYCLES-1, go to WAIT_MSB and pulse frame_err.
REQ-026 If a byte event and the timeout occur in the same cycle, the byte event SHALL win and no frame_err is raised.
REQ-027 Latency SHALL be fixed: sample_valid rises 3 cycles after the first clk edge that samples byte_valid high for the LSB.
REQ-028 sample_out and sample_unit SHALL hold their values between pulses.
REQ-029 busy SHALL equal (state == WAIT_LSB).
REQ-030 err_count SHALL increment on each frame_err and saturate at 255 without wrapping.
REQ-031 ena low SHALL freeze the FSM and the timeout counter; the pipeline keeps running.

Reset
REQ-032 While rst is high, all outputs, pipeline registers, the FSM, msb_reg, unit_reg and the counters SHALL reset to 0 or WAIT_MSB immediately and asynchronously.
REQ-033 Reset asserted mid-pair SHALL discard the held MSB, and the first byte after reset SHALL be treated as an MSB.

Verification
REQ-034 Bytes 0x12, 0x34 on unit 1, each strobed for 1 cycle with a 1-cycle gap -> one sample_valid pulse, sample_out=0x1234, sample_unit=1, unit_valid=2'b10.
REQ-035 Back-to-back pairs unit0 0x8001 then unit1 0x7FFF -> two pulses in order with the correct unit_valid bits, and no frame_err.
REQ-036 MSB 0xAA on unit 0, then no byte for 64 cycles -> frame_err once, err_count=1, busy low; then 0x01, 0x02 on unit 0 -> sample_out=0x0102.
REQ-037 MSB on unit 0, next byte 0x55 on unit 1 -> frame_err, busy stays high with 0x55 as the MSB; LSB 0x66 on unit 1 -> sample_out=0x5566.
REQ-038 Strobe held high for 5 cycles -> only one byte is accepted. unit_sel=3 with NUM_UNITS=2 -> frame_err and no state change. rst pulsed with busy high -> busy=0 and err_count=0.
REQ-039 Generate 300 malformed events -> err_count stays at 255.
